twiddle_quadrant_gen: RTL and testbench

//   Upstream address/sign stage for the 64-entry quarter-wave sine ROM (1-cycle registered read).

---
 rtl/twiddle_quadrant_gen.sv | 223 ++++++++++++++++++++++
 tb/tb_twiddle_quadrant_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_quadrant_gen.sv
// twiddle_quadrant_gen
//   Address/sign stage in front of a 64-entry quarter-wave sine ROM that has a
//   1-cycle registered read. Walks phase = start_phase + n*phase_step (mod 256),
//   folds each phase onto the quarter table, applies the quadrant sign and hands
//   signed twiddles to the butterfly over a valid/ready handshake.
//
//   Build option TWIDDLE_COS_EN:
//     defined   - sin and cos pairs, RD_SIN -> RD_COS -> CAP_COS -> OUT, 4 cycles/point.
//     undefined - sin only, RD_COS captures sin and goes to OUT, out_cos is 0,
//                 3 cycles/point.
module twiddle_quadrant_gen #(
  parameter int QIDX_W = 6,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [QIDX_W+1:0]   start_phase,
  input  logic [QIDX_W+1:0]   phase_step,
  input  logic [QIDX_W+1:0]   num_points,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_data,
  output logic [DATA_W-1:0]   out_sin,
  output logic [DATA_W-1:0]   out_cos,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);

  // Phase is two quadrant bits above the quarter-table index.
  localparam int PH_W  = QIDX_W + 2;
  // One extra count bit so that num_points == 0 can stand for a full turn.
  localparam int CNT_W = PH_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SIN,
    S_RD_COS,
    S_CAP_COS,
    S_OUT
  } state_e;

  // ---------------------------------------------------------------------------
  // Phase folding helpers
  // ---------------------------------------------------------------------------

  // Quarter-table address for a phase: odd quadrants read the table mirrored
  // (63 - i, i.e. the bitwise complement of the index); upper address bits 0.
  function automatic logic [ADDR_W-1:0] rom_addr_of(input logic [PH_W-1:0] p);
    logic [QIDX_W-1:0] idx;
    idx = p[QIDX_W] ? ~p[QIDX_W-1:0] : p[QIDX_W-1:0];
    return {{(ADDR_W-QIDX_W){1'b0}}, idx};
  endfunction

  // Table magnitudes never exceed 127, so the negation cannot overflow.
  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                    input logic              neg);
    return neg ? (~mag + DATA_W'(1)) : mag;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e              state_q,    state_d;
  logic [PH_W-1:0]     phase_q,    phase_d;
  logic [PH_W-1:0]     step_q,     step_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0]   sin_q,      sin_d;
  logic                valid_q,    valid_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;

`ifdef TWIDDLE_COS_EN
  // cos(p) is sin(p + quarter turn) through the same fold.
  localparam logic [PH_W-1:0] QTR_TURN = PH_W'(1) << QIDX_W;

  logic [DATA_W-1:0]   cos_q,      cos_d;
  logic [PH_W-1:0]     cos_phase;

  assign cos_phase = phase_q + QTR_TURN;
`endif

  // Next-state, datapath updates and the ROM address for the state being entered.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    phase_d    = phase_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    sin_d      = sin_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rom_addr_d = '0;
`ifdef TWIDDLE_COS_EN
    cos_d      = cos_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // start is only looked at here, which also makes the done cycle a valid
        // start cycle since the machine is already back in IDLE then.
        if (start) begin
          phase_d = start_phase;
          step_d  = phase_step;
          cnt_d   = (num_points == '0) ? {1'b1, {PH_W{1'b0}}} : {1'b0, num_points};
          busy_d  = 1'b1;
          state_d = S_RD_SIN;
        end
      end

      S_RD_SIN: begin
        state_d = S_RD_COS;
      end

      S_RD_COS: begin
        // The sin word addressed in RD_SIN is on rom_data now.
        sin_d = apply_sign(rom_data, phase_q[PH_W-1]);
`ifdef TWIDDLE_COS_EN
        state_d = S_CAP_COS;
`else
        valid_d = 1'b1;
        state_d = S_OUT;
`endif
      end

      S_CAP_COS: begin
`ifdef TWIDDLE_COS_EN
        cos_d   = apply_sign(rom_data, cos_phase[PH_W-1]);
        valid_d = 1'b1;
        state_d = S_OUT;
`else
        state_d = S_IDLE;
`endif
      end

      S_OUT: begin
        // Outputs stay frozen until the consumer takes the pair.
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          phase_d = phase_q + step_q;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_d == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_RD_SIN;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // rom_addr is registered, so it is computed from the state about to be
    // entered and the phase that state will see. Everything else reads address 0.
    // NOTE: blocking assignments in combinational logic, so state_d/phase_d above
    // are already final when read here.
    unique case (state_d)
      S_RD_SIN: rom_addr_d = rom_addr_of(phase_d);
`ifdef TWIDDLE_COS_EN
      S_RD_COS: rom_addr_d = rom_addr_of(phase_d + QTR_TURN);
`endif
      default:  rom_addr_d = '0;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register, outputs included;
    // there is no storage array here that would need to be left out of reset.
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      step_q     <= '0;
      cnt_q      <= '0;
      rom_addr_q <= '0;
      sin_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      phase_q    <= phase_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      rom_addr_q <= rom_addr_d;
      sin_q      <= sin_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef TWIDDLE_COS_EN
  // cos output register, cleared by reset like the rest of the datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      cos_q <= '0;
    end else begin
      cos_q <= cos_d;
    end
  end

  assign out_cos = cos_q;
`else
  assign out_cos = '0;
`endif

  assign rom_addr  = rom_addr_q;
  assign out_sin   = sin_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_twiddle_quadrant_gen.sv
// Bench for twiddle_quadrant_gen, paired with a quarter-wave sine ROM model
// (1-cycle registered read, T[i] = round(127*sin(2*pi*(i+0.5)/256))).
// Expected twiddles come from quadrant arithmetic on the phase sequence.
module tb_twiddle_quadrant_gen;

`ifdef TWIDDLE_COS_EN
  localparam bit COS_EN = 1'b1;
`else
  localparam bit COS_EN = 1'b0;
`endif
  localparam int  CPP = COS_EN ? 4 : 3;
  localparam real PI  = 3.14159265358979;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       out_ready;
  logic [7:0] start_phase;
  logic [7:0] phase_step;
  logic [7:0] num_points;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] out_sin;
  logic [7:0] out_cos;
  logic       out_valid;
  logic       busy;
  logic       done;

  logic [7:0] rom [64];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  logic [7:0] seen_sin [$];
  logic [7:0] seen_cos [$];

  logic [7:0] vec_a_sin [4] = '{8'h02, 8'h7F, 8'hFE, 8'h81};
  logic [7:0] vec_a_cos [4] = '{8'h7F, 8'hFE, 8'h81, 8'h02};
  logic [7:0] vec_c_sin [2] = '{8'h7F, 8'h81};
  logic [7:0] vec_c_cos [2] = '{8'hFE, 8'h02};

  twiddle_quadrant_gen dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_phase (start_phase),
    .phase_step  (phase_step),
    .num_points  (num_points),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_sin     (out_sin),
    .out_cos     (out_cos),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Quarter-wave ROM with registered read.
  always @(posedge clk) rom_data <= rom[rom_addr[5:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Table address for phase p: quadrant q = p/64, offset i = p%64, odd quadrants mirrored.
  function automatic logic [7:0] ref_idx(input int p);
    int q;
    int i;
    q = (p % 256) / 64;
    i = p % 64;
    return (q % 2 == 1) ? 8'(63 - i) : 8'(i);
  endfunction

  // sin(2*pi*p/256)*127 as the table gives it: magnitude from the quarter table,
  // negative in the lower half-turn.
  function automatic logic [7:0] ref_val(input int p);
    int q;
    int mag;
    q   = (p % 256) / 64;
    mag = (q % 2 == 0) ? int'(rom[6'(p % 64)]) : int'(rom[6'(63 - p % 64)]);
    return 8'((q >= 2) ? -mag : mag);
  endfunction

  // One full sequence: start, then per point check addresses, latency, values,
  // optional stall with stability checks, handshake; finally the done pulse.
  task automatic run_seq(input logic [7:0] sp, input logic [7:0] st, input logic [7:0] np,
                         input int stall_min, input int stall_max,
                         input bit rnd_ready, input bit poke, input bit chain);
    int         npts;
    int         cyc;
    int         stall;
    int         ph;
    logic [7:0] es;
    logic [7:0] ec;
    npts        = (np == 8'd0) ? 256 : int'(np);
    start_phase = sp;
    phase_step  = st;
    num_points  = np;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    start_phase = 8'($urandom);
    phase_step  = 8'($urandom);
    num_points  = 8'($urandom);
    for (int k = 0; k < npts; k++) begin
      ph = (int'(sp) + k * int'(st)) % 256;
      es = ref_val(ph);
      ec = COS_EN ? ref_val(ph + 64) : 8'h00;
      chk("busy_run", busy, 1'b1);
      chk("done_run", done, 1'b0);
      chk("addr_sin", rom_addr, ref_idx(ph));
      if (poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("addr_cos", rom_addr, COS_EN ? ref_idx(ph + 64) : 8'h00);
      cyc = 2;
      while (out_valid !== 1'b1 && cyc < 16) begin
        out_ready = rnd_ready ? 1'($urandom) : 1'b0;
        @(negedge clk);
        cyc++;
      end
      chk("latency", cyc, CPP);
      chk("sin", out_sin, es);
      chk("cos", out_cos, ec);
      seen_sin.push_back(out_sin);
      seen_cos.push_back(out_cos);
      stall     = int'($urandom_range(stall_max, stall_min));
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        if (poke) begin
          start       = 1'b1;
          start_phase = 8'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_sin", out_sin, es);
        chk("hold_cos", out_cos, ec);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("valid_drop", out_valid, 1'b0);
    end
    chk("done_pulse", done, 1'b1);
    chk("busy_end", busy, 1'b0);
    chk("addr_idle", rom_addr, 8'h00);
    if (!chain) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk("done_once", done, 1'b0);
        chk("no_extra", out_valid | busy, 1'b0);
      end
    end
  endtask

  initial begin
    int         cyc;
    int         p2;
    logic [7:0] sp_r;
    logic [7:0] st_r;

    for (int i = 0; i < 64; i++)
      rom[6'(i)] = 8'($rtoi(127.0 * $sin(2.0 * PI * (real'(i) + 0.5) / 256.0) + 0.5));

    reset       = 1'b1;
    start       = 1'b0;
    out_ready   = 1'b0;
    start_phase = 8'h00;
    phase_step  = 8'h00;
    num_points  = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_addr", rom_addr, 8'h00);
    chk("rst_sin", out_sin, 8'h00);
    chk("rst_cos", out_cos, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // Four quadrant points at step 64.
    seen_sin.delete();
    seen_cos.delete();
    run_seq(8'd0, 8'd64, 8'd4, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("vec_a_sin", seen_sin[k], vec_a_sin[2'(k)]);
      chk("vec_a_cos", seen_cos[k], COS_EN ? vec_a_cos[2'(k)] : 8'h00);
    end

    // Last phase of the turn, single point.
    seen_sin.delete();
    seen_cos.delete();
    run_seq(8'd255, 8'($urandom), 8'd1, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("vec_b_sin", seen_sin[0], 8'hFE);
    chk("vec_b_cos", seen_cos[0], COS_EN ? 8'h7F : 8'h00);

    // Half-turn step from 64.
    seen_sin.delete();
    seen_cos.delete();
    run_seq(8'd64, 8'd128, 8'd2, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("vec_c_sin", seen_sin[k], vec_c_sin[1'(k)]);
      chk("vec_c_cos", seen_cos[k], COS_EN ? vec_c_cos[1'(k)] : 8'h00);
    end

    // num_points = 0 runs a full 256-point turn with wrap.
    seen_sin.delete();
    seen_cos.delete();
    run_seq(8'($urandom), 8'd1, 8'd0, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("full_turn_count", seen_sin.size(), 256);

    // Five-cycle stalls with start pulses while busy.
    run_seq(8'($urandom), 8'($urandom), 8'd3, 5, 5, 1'b0, 1'b1, 1'b0);

    // Second start issued in the done cycle.
    run_seq(8'($urandom), 8'($urandom), 8'd2, 0, 1, 1'b1, 1'b0, 1'b1);
    run_seq(8'($urandom), 8'($urandom), 8'd2, 0, 1, 1'b1, 1'b0, 1'b0);

    // Reset during RD_COS of point 2.
    sp_r        = 8'($urandom);
    st_r        = 8'($urandom);
    p2          = (int'(sp_r) + int'(st_r)) % 256;
    start_phase = sp_r;
    phase_step  = st_r;
    num_points  = 8'd3;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (out_valid !== 1'b1 && cyc < 16) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_seq_latency", cyc, CPP);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_seq_addr", rom_addr, COS_EN ? ref_idx(p2 + 64) : 8'h00);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_addr", rom_addr, 8'h00);
    chk("mid_rst_sin", out_sin, 8'h00);
    chk("mid_rst_cos", out_cos, 8'h00);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", done | busy | out_valid, 1'b0);
    end
    run_seq(8'($urandom), 8'($urandom), 8'd3, 0, 0, 1'b0, 1'b0, 1'b0);

    // Random sequences with random ready and stalls.
    for (int r = 0; r < 6; r++) begin
      run_seq(8'($urandom), 8'($urandom), 8'($urandom_range(6, 1)), 0, 3, 1'b1, 1'b1,
              (r % 2 == 1) && (r < 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
